// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 8-digit seven-segment scanner with frame snapshot and anode dead-time
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] SEVENSEGHEX,
    output logic [6:0]  SEVENSEGCAT,
    output logic [7:0]  SEVENSEGAN,
    output logic        FRAME_DONE
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_next;
    logic [2:0]    idx, idx_next;
    logic [BW-1:0] blank_cnt, blank_cnt_next;
    logic [DW-1:0] dwell_cnt, dwell_cnt_next;
    logic [31:0]   snap, snap_next;
    logic [31:0]   live;
    logic [3:0]    nib;
    logic [7:0]    an, an_next;
    logic [6:0]    cat, cat_next;
    logic          done, done_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= BLANK;
            idx       <= 3'd0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            snap      <= 32'd0;
            an        <= 8'hFF;
            cat       <= 7'h7F;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            blank_cnt <= blank_cnt_next;
            dwell_cnt <= dwell_cnt_next;
            snap      <= snap_next;
            an        <= an_next;
            cat       <= cat_next;
            done      <= done_next;
        end
    end

    // During digit-0 BLANK the live input is both captured and decoded, so the
    // digit-0 entry edge shows exactly the value the snapshot takes.
    always_comb begin
        live = (state == BLANK && idx == 3'd0) ? SEVENSEGHEX : snap;
        nib  = live[{idx, 2'b00} +: 4];

        state_next     = state;
        idx_next       = idx;
        blank_cnt_next = blank_cnt;
        dwell_cnt_next = dwell_cnt;
        snap_next      = live;
        an_next        = an;
        cat_next       = cat;
        done_next      = 1'b0;

        case (state)
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_next     = SHOW;
                    blank_cnt_next = '0;
                    an_next        = ~(8'd1 << idx);
                    cat_next       = seg_decode(nib);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
                    if (idx != 3'd0 && (live >> {idx, 2'b00}) == 32'd0)
                        an_next = 8'hFF;
`endif
                end else begin
                    blank_cnt_next = blank_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_next     = BLANK;
                    dwell_cnt_next = '0;
                    idx_next       = idx + 3'd1;
                    an_next        = 8'hFF;
                    cat_next       = 7'h7F;
                    done_next      = (idx == 3'd7);
                end else begin
                    dwell_cnt_next = dwell_cnt + 1'b1;
                end
            end
            default: state_next = BLANK;
        endcase
    end

    assign SEVENSEGAN  = an;
    assign SEVENSEGCAT = cat;
    assign FRAME_DONE  = done;

endmodule
